dp_byte_mem: RTL and testbench
==============================

# dp_byte_mem

Parametrised dual-port behavioural memory for the GPC tiles, serving both core instruction/data fetch and ring access. It generalises the fixed 32-bit dual-port memory in three ways:
- configurable word width, depth and read latency;
- per-port byte enables with defined same-address collision rules;
- a post-reset clear engine that zeroes the array and reports `init_done`.

Port A is the core side and port B is the ring side.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `ADDR_W`, 10: word address width; depth = 2^ADDR_W words.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 and 2.
- `WR_FIRST`, 0: read-during-write policy. 1 returns new data; 0 returns old data.
- `CLEAR_ON_RST`, 1: 1 enables the post-reset zero-fill engine.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `address_a`  in  ADDR_W  port A word address.
- `data_a`  in  DATA_W  port A write data.
- `be_a`  in  DATA_W/8  port A byte enables; bit i covers `data_a[8i+7:8i]`.
- `rden_a`  in  1  port A read request.
- `wren_a`  in  1  port A write request.
- `q_a`  out  DATA_W  port A read data.
- `rvalid_a`  out  1  `q_a` is valid this cycle.
- `address_b`, `data_b`, `be_b`, `rden_b`, `wren_b`, `q_b`, `rvalid_b`: same as port A, for port B.
- `init_done`  out  1  array is ready for access.
- `wr_collision`  out  1  one-cycle pulse: both ports wrote the same word with overlapping byte enables.

## Operation
- **State machine** (two states):
  - CLEAR: one word is zeroed per cycle at `clr_ptr`.
  - READY: normal access.
- **Reset (`rst`=1 at a clock edge):**
  - State → CLEAR if `CLEAR_ON_RST`=1, otherwise READY.
  - `clr_ptr` → 0.
  - Read pipelines are flushed.
  - `q_a`, `q_b`, `rvalid_a`, `rvalid_b`, `wr_collision` → 0.
  - `init_done` → 0 if `CLEAR_ON_RST`=1, otherwise 1.
  - Array contents are not touched by reset itself.
- **CLEAR state:**
  - Writes zero to word `clr_ptr`, then increments `clr_ptr`.
  - On `clr_ptr` = 2^ADDR_W−1, moves to READY. The counter is ADDR_W bits wide and wraps to 0.
  - All `rden`/`wren` inputs are ignored: no array change, no `rvalid`.
  - Reset asserted mid-clear restarts the clear from word 0.
- **Writes (READY):** for each byte i with `wren_x` & `be_x[i]`, mem[addr][i] ← `data_x` byte i. Bytes with `be` low are unchanged.
- **Same-address dual write:**
  - Bytes enabled on both ports take port A data.
  - Bytes enabled on only one port take that port's data.
  - If the byte enables overlap, `wr_collision` pulses on the next cycle.
- **Reads (READY):**
  - `rden_x` samples mem[`address_x`] at the edge.
  - Result appears on `q_x` with `rvalid_x`=1 exactly RD_LAT cycles later.
  - When `rvalid_x`=0, `q_x` = 0.
- **Read-during-write** (same word, either port, same cycle):
  - `WR_FIRST`=1: read returns the post-write merged word, including the port-A-priority merge.
  - `WR_FIRST`=0: read returns the pre-write word.
- A port may read and write in the same cycle. Both ports may read in the same cycle with no restriction.
- Addresses are word-granular; no misalignment is possible.

## Timing
- Clear duration: 2^ADDR_W cycles after the first edge with `rst`=0. `init_done` rises on the edge that writes the last word; it is high from the next cycle.
- First accepted access: the cycle `init_done`=1.
- RD_LAT=1: `rden` sampled at edge n → `q`/`rvalid` valid during cycle n+1.
- RD_LAT=2: output valid during cycle n+2. Back-to-back reads are fully pipelined, one result per cycle per port.
- Write at edge n is visible to a read sampled at edge n+1, regardless of `WR_FIRST`.
- `wr_collision` is registered: it is high for the cycle following the colliding edge.
- A read in flight when `rst` asserts is dropped; its `rvalid` never appears.

## Test plan
- **Clear after reset.** Config ADDR_W=4, CLEAR_ON_RST=1. Preload via writes, pulse `rst` for 1 cycle.
  - `init_done` rises exactly 16 cycles after `rst` falls.
  - Every word then reads 0x00000000.
  - Accesses issued during CLEAR produce no `rvalid` and no array change.
- **Byte-enable merge.** Port A writes 0x11223344 (be=4'hF) to word 5, then port B writes 0xAABBCCDD with be=4'b0101.
  - Port A read of word 5 returns 0x11BB33DD after RD_LAT cycles.
- **Dual-write collision.** Same cycle to word 7: A writes 0x01020304 with be=4'b0011, B writes 0x0A0B0C0D with be=4'b0110.
  - Word 7 = 0x000B0304 (starting from a cleared array).
  - `wr_collision` is high for exactly one cycle.
- **Read-during-write.** Word 3 holds 0xDEADBEEF. Port A writes 0xCAFEF00D while port B reads word 3.
  - `q_b` = 0xCAFEF00D with `WR_FIRST`=1.
  - `q_b` = 0xDEADBEEF with `WR_FIRST`=0.
- **Pipelined reads.** RD_LAT=2, port A reads words 0,1,2,3 on consecutive cycles.
  - `rvalid_a` is high for 4 consecutive cycles starting 2 cycles after the first request, with data in order.
  - `q_a` = 0 on all other cycles.
- **Reset mid-operation.** Assert `rst` at clear word 9, and separately with a read in flight.
  - Clear restarts at 0; full 16-cycle duration again.
  - The in-flight read produces no `rvalid`.
  - All outputs are 0 the cycle after the reset edge.

Source files
------------

// File: rtl/dp_byte_mem.sv
// Dual-port byte-enabled memory with configurable read latency, read-during-write
// policy and a post-reset zero-fill engine. Port A is the core side, port B the ring side.
module dp_byte_mem #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned WR_FIRST     = 0,
   parameter int unsigned CLEAR_ON_RST = 1
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     address_a,
   input  logic [DATA_W-1:0]     data_a,
   input  logic [DATA_W/8-1:0]   be_a,
   input  logic                  rden_a,
   input  logic                  wren_a,
   output logic [DATA_W-1:0]     q_a,
   output logic                  rvalid_a,
   input  logic [ADDR_W-1:0]     address_b,
   input  logic [DATA_W-1:0]     data_b,
   input  logic [DATA_W/8-1:0]   be_b,
   input  logic                  rden_b,
   input  logic                  wren_b,
   output logic [DATA_W-1:0]     q_b,
   output logic                  rvalid_b,
   output logic                  init_done,
   output logic                  wr_collision
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {StClear, StReady} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                ready;
   logic                same_addr;
   logic [DATA_W-1:0]   post_a, post_b;
   logic [DATA_W-1:0]   rd_a, rd_b;
   logic                v1_a, v2_a, v1_b, v2_b;
   logic [DATA_W-1:0]   d1_a, d2_a, d1_b, d2_b;

   assign ready     = (state == StReady);
   assign same_addr = (address_a == address_b);

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      if (state == StClear) begin
         clr_ptr_nxt = clr_ptr + 1'b1;
         if (clr_ptr == '1) state_nxt = StReady;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= (CLEAR_ON_RST != 0) ? StClear : StReady;
         clr_ptr   <= '0;
         init_done <= (CLEAR_ON_RST == 0);
      end else begin
         state     <= state_nxt;
         clr_ptr   <= clr_ptr_nxt;
         init_done <= (state_nxt == StReady);
      end
   end

   // Post-write word at each port's address; on a shared address port A bytes win.
   always_comb begin
      post_a = mem[address_a];
      post_b = mem[address_b];
      for (int i = 0; i < NB; i++) begin
         if (wren_b && be_b[i]) post_b[8*i +: 8] = data_b[8*i +: 8];
         if (wren_a && be_a[i] && same_addr) post_b[8*i +: 8] = data_a[8*i +: 8];
         if (wren_b && be_b[i] && same_addr) post_a[8*i +: 8] = data_b[8*i +: 8];
         if (wren_a && be_a[i]) post_a[8*i +: 8] = data_a[8*i +: 8];
      end
   end

   assign rd_a = (WR_FIRST != 0) ? post_a : mem[address_a];
   assign rd_b = (WR_FIRST != 0) ? post_b : mem[address_b];

   // Port A written last so its merged word wins when both ports hit one address.
   always_ff @(posedge clock) begin
      if (!rst) begin
         if (state == StClear) begin
            mem[clr_ptr] <= '0;
         end else begin
            if (wren_b) mem[address_b] <= post_b;
            if (wren_a) mem[address_a] <= post_a;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         v1_a         <= 1'b0;
         v2_a         <= 1'b0;
         v1_b         <= 1'b0;
         v2_b         <= 1'b0;
         d1_a         <= '0;
         d2_a         <= '0;
         d1_b         <= '0;
         d2_b         <= '0;
         wr_collision <= 1'b0;
      end else begin
         v1_a         <= ready && rden_a;
         d1_a         <= (ready && rden_a) ? rd_a : '0;
         v2_a         <= v1_a;
         d2_a         <= d1_a;
         v1_b         <= ready && rden_b;
         d1_b         <= (ready && rden_b) ? rd_b : '0;
         v2_b         <= v1_b;
         d2_b         <= d1_b;
         wr_collision <= ready && wren_a && wren_b && same_addr && (|(be_a & be_b));
      end
   end

   assign rvalid_a = (RD_LAT == 2) ? v2_a : v1_a;
   assign q_a      = (RD_LAT == 2) ? d2_a : d1_a;
   assign rvalid_b = (RD_LAT == 2) ? v2_b : v1_b;
   assign q_b      = (RD_LAT == 2) ? d2_b : d1_b;
endmodule

// File: tb/tb_dp_byte_mem.sv
// Drives two dp_byte_mem configurations (RD_LAT=1/old-data, RD_LAT=2/new-data) with shared
// stimulus; a byte-array reference model fills per-port scoreboards checked by a monitor.
module tb_dp_byte_mem;
   localparam int NW = 16;

   typedef struct packed {
      logic [31:0] d;
      int          due;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic [3:0]  address_a = '0, address_b = '0;
   logic [31:0] data_a = '0, data_b = '0;
   logic [3:0]  be_a = '0, be_b = '0;
   logic        rden_a = 1'b0, wren_a = 1'b0, rden_b = 1'b0, wren_b = 1'b0;

   // Index p: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
   logic [31:0] q  [4];
   logic        rv [4];
   logic        idn [2];
   logic        col [2];

   exp_t        sb [4][$];
   logic [7:0]  mm [NW][4];
   int          clear_left = 0;
   logic        exp_init = 1'b0, exp_coll = 1'b0;
   logic        armed = 1'b0;
   int          cyc = 0;
   int          errors = 0, checks = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   dp_byte_mem #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .WR_FIRST(0), .CLEAR_ON_RST(1)) u0 (
      .clock(clock), .rst(rst),
      .address_a(address_a), .data_a(data_a), .be_a(be_a), .rden_a(rden_a), .wren_a(wren_a),
      .q_a(q[0]), .rvalid_a(rv[0]),
      .address_b(address_b), .data_b(data_b), .be_b(be_b), .rden_b(rden_b), .wren_b(wren_b),
      .q_b(q[1]), .rvalid_b(rv[1]),
      .init_done(idn[0]), .wr_collision(col[0])
   );

   dp_byte_mem #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .WR_FIRST(1), .CLEAR_ON_RST(1)) u1 (
      .clock(clock), .rst(rst),
      .address_a(address_a), .data_a(data_a), .be_a(be_a), .rden_a(rden_a), .wren_a(wren_a),
      .q_a(q[2]), .rvalid_a(rv[2]),
      .address_b(address_b), .data_b(data_b), .be_b(be_b), .rden_b(rden_b), .wren_b(wren_b),
      .q_b(q[3]), .rvalid_b(rv[3]),
      .init_done(idn[1]), .wr_collision(col[1])
   );

   // Reference model: advance by one clock edge using the currently driven inputs.
   task automatic step();
      int          e;
      logic [7:0]  nx [NW][4];
      logic [31:0] pre_a, pre_b, new_a, new_b;
      e = cyc + 1;
      if (rst) begin
         for (int p = 0; p < 4; p++) sb[p].delete();
         clear_left = NW;
         exp_init   = 1'b0;
         exp_coll   = 1'b0;
         return;
      end
      if (clear_left > 0) begin
         for (int i = 0; i < 4; i++) mm[NW - clear_left][i] = 8'h00;
         clear_left--;
         exp_init = (clear_left == 0);
         exp_coll = 1'b0;
         return;
      end
      exp_coll = wren_a && wren_b && (address_a == address_b) && ((be_a & be_b) != 4'h0);
      nx = mm;
      for (int i = 0; i < 4; i++)
         if (wren_b && be_b[i]) nx[address_b][i] = data_b[8*i +: 8];
      for (int i = 0; i < 4; i++)
         if (wren_a && be_a[i]) nx[address_a][i] = data_a[8*i +: 8];
      for (int i = 0; i < 4; i++) begin
         pre_a[8*i +: 8] = mm[address_a][i];
         pre_b[8*i +: 8] = mm[address_b][i];
         new_a[8*i +: 8] = nx[address_a][i];
         new_b[8*i +: 8] = nx[address_b][i];
      end
      if (rden_a) begin
         sb[0].push_back('{d: pre_a, due: e});
         sb[2].push_back('{d: new_a, due: e + 1});
      end
      if (rden_b) begin
         sb[1].push_back('{d: pre_b, due: e});
         sb[3].push_back('{d: new_b, due: e + 1});
      end
      mm = nx;
   endtask

   task automatic tick();
      step();
      @(posedge clock);
      #2;
   endtask

   task automatic op(input logic ra, input logic wa, input logic [3:0] aa, input logic [31:0] da,
                     input logic [3:0] ba, input logic rb, input logic wb, input logic [3:0] ab,
                     input logic [31:0] db, input logic [3:0] bb);
      rden_a = ra; wren_a = wa; address_a = aa; data_a = da; be_a = ba;
      rden_b = rb; wren_b = wb; address_b = ab; data_b = db; be_b = bb;
      tick();
   endtask

   task automatic idle();
      op(0, 0, 4'h0, 32'h0, 4'h0, 0, 0, 4'h0, 32'h0, 4'h0);
   endtask

   task automatic rnd(input int amax);
      op(1'($urandom), 1'($urandom), 4'($urandom_range(amax, 0)), $urandom, 4'($urandom),
         1'($urandom), 1'($urandom), 4'($urandom_range(amax, 0)), $urandom, 4'($urandom));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rnd(15);
      rst = 1'b0;
   endtask

   task automatic readback();
      for (int w = 0; w < NW; w++) op(1, 0, 4'(w), 32'h0, 4'h0, 1, 0, 4'(15 - w), 32'h0, 4'h0);
   endtask

   initial begin : monitor
      exp_t f;
      forever begin
         @(posedge clock);
         #1;
         if (armed) begin
            for (int p = 0; p < 4; p++) begin
               checks++;
               if (rv[p]) begin
                  if (sb[p].size() == 0) begin
                     errors++;
                     $display("FAIL rvalid[%0d] cyc=%0d: got rvalid=1 q=%h, required rvalid=0",
                              p, cyc, q[p]);
                  end else begin
                     f = sb[p][0];
                     if (f.due != cyc) begin
                        errors++;
                        $display("FAIL latency[%0d] cyc=%0d: rvalid=1, required at cyc %0d",
                                 p, cyc, f.due);
                        if (f.due < cyc) void'(sb[p].pop_front());
                     end else begin
                        void'(sb[p].pop_front());
                        if (q[p] !== f.d) begin
                           errors++;
                           $display("FAIL rdata[%0d] cyc=%0d: got %h, required %h",
                                    p, cyc, q[p], f.d);
                        end
                     end
                  end
               end else begin
                  if (q[p] !== 32'h0) begin
                     errors++;
                     $display("FAIL qidle[%0d] cyc=%0d: got %h, required 0", p, cyc, q[p]);
                  end
                  if (sb[p].size() != 0) begin
                     f = sb[p][0];
                     if (f.due <= cyc) begin
                        errors++;
                        $display("FAIL missing[%0d] cyc=%0d: rvalid=0, required 1 with %h",
                                 p, cyc, f.d);
                        void'(sb[p].pop_front());
                     end
                  end
               end
            end
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (idn[k] !== exp_init) begin
                  errors++;
                  $display("FAIL init_done[%0d] cyc=%0d: got %b, required %b",
                           k, cyc, idn[k], exp_init);
               end
               checks++;
               if (col[k] !== exp_coll) begin
                  errors++;
                  $display("FAIL wr_collision[%0d] cyc=%0d: got %b, required %b",
                           k, cyc, col[k], exp_coll);
               end
            end
         end
      end
   end

   initial begin : stimulus
      @(posedge clock);
      #2;
      armed = 1'b1;
      do_reset();
      // Accesses during the clear must be ignored.
      for (int i = 0; i < 16; i++) rnd(15);
      // Byte-enable merge on word 5.
      op(0, 1, 4'd5, 32'h11223344, 4'hF, 0, 0, 4'd0, 32'h0, 4'h0);
      op(0, 0, 4'd0, 32'h0, 4'h0, 0, 1, 4'd5, 32'hAABBCCDD, 4'b0101);
      op(1, 0, 4'd5, 32'h0, 4'h0, 0, 0, 4'd0, 32'h0, 4'h0);
      // Same-word dual write with overlapping enables.
      op(0, 1, 4'd7, 32'h01020304, 4'b0011, 0, 1, 4'd7, 32'h0A0B0C0D, 4'b0110);
      op(1, 0, 4'd7, 32'h0, 4'h0, 1, 0, 4'd7, 32'h0, 4'h0);
      // Read-during-write on word 3.
      op(0, 1, 4'd3, 32'hDEADBEEF, 4'hF, 0, 0, 4'd0, 32'h0, 4'h0);
      op(0, 1, 4'd3, 32'hCAFEF00D, 4'hF, 1, 0, 4'd3, 32'h0, 4'h0);
      // Back-to-back pipelined reads.
      for (int w = 0; w < 4; w++) op(1, 0, 4'(w), 32'h0, 4'h0, 0, 0, 4'd0, 32'h0, 4'h0);
      repeat (3) idle();
      for (int i = 0; i < 300; i++) rnd(7);
      for (int i = 0; i < 200; i++) rnd(15);
      // Reset with array populated; clear, then everything reads zero.
      do_reset();
      for (int i = 0; i < 16; i++) rnd(15);
      readback();
      for (int i = 0; i < 60; i++) rnd(15);
      // Reset at clear word 9 restarts the full clear.
      do_reset();
      repeat (9) idle();
      do_reset();
      for (int i = 0; i < 16; i++) rnd(15);
      readback();
      // Reset with reads in flight.
      for (int i = 0; i < 40; i++) rnd(15);
      op(1, 1, 4'd2, $urandom, 4'hF, 1, 0, 4'd2, 32'h0, 4'h0);
      do_reset();
      for (int i = 0; i < 16; i++) idle();
      for (int i = 0; i < 100; i++) rnd(15);
      readback();
      repeat (4) idle();
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (sb[p].size() != 0) begin
            errors++;
            $display("FAIL drain[%0d]: %0d reads outstanding, required 0", p, sb[p].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
